// File: rtl/weight_load_ctrl_pkg.sv
// Shared types and default sizing for the systolic-array weight-load sequencer.
// The state enum and default geometry are used by RTL and bench alike.
package wlc_pkg;

  typedef enum logic [2:0] {
    WLC_IDLE  = 3'd0,
    WLC_FETCH = 3'd1,
    WLC_LATCH = 3'd2,
    WLC_RUN   = 3'd3,
    WLC_DONE  = 3'd4
  } wlc_state_e;

  // One filter word packs 2 PE rows x 9 weights of M bits each
  localparam int WLC_PE_ROWS      = 2;
  localparam int WLC_ELEMS_PER_ROW = 9;
  localparam int WLC_M_DEF        = 8;
  localparam int WLC_N_W_DEF      = WLC_PE_ROWS * WLC_ELEMS_PER_ROW;
  localparam int WLC_N_FILTER_DEF = 8;
  localparam int WLC_ADDR_W_DEF   = 8;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Bundle between the weight-load sequencer and its neighbours (start logic, weight ROM,
// PE weight registers, fmap buffer). master = sequencer side, slave = environment side.
interface weight_load_ctrl_if #(
  parameter int M      = 8,
  parameter int N_W    = 18,
  parameter int ADDR_W = 8
);
  logic                start;
  logic                fmap_finish;
  logic                mem_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [M*N_W-1:0]    mem_dout;
  logic [M*N_W-1:0]    w_data;
  logic                w_valid;
  logic                fmap_start;
  logic [7:0]          filter_count;
  logic                filter_finish;
  logic                busy;

  modport master (
    input  start, fmap_finish, mem_dout,
    output mem_en, mem_addr, w_data, w_valid, fmap_start,
           filter_count, filter_finish, busy
  );

  modport slave (
    output start, fmap_finish, mem_dout,
    input  mem_en, mem_addr, w_data, w_valid, fmap_start,
           filter_count, filter_finish, busy
  );
endinterface

// File: rtl/weight_load_ctrl_shadow_reg.sv
// Shadow holding register for the prefetched next-filter weight word, plus its valid bit.
// Only exists in builds with WLC_PREFETCH_EN defined.
`ifdef WLC_PREFETCH_EN
module wlc_shadow_reg #(
  parameter int W = 144
) (
  input  logic         clk,
  input  logic         Rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         valid_o
);
  logic [W-1:0] data_q;
  logic         valid_q;

  // clear wins over load so a late capture cannot resurrect a consumed/aborted word
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i && !clear_i) data_q <= d_i;
      if (clear_i)            valid_q <= 1'b0;
      else if (load_i)        valid_q <= 1'b1;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;
endmodule
`endif

// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: fetches each filter's weight word from ROM, strobes it into the
// PE array and starts the fmap pass. Define WLC_PREFETCH_EN for next-filter prefetch.
//
// state     | meaning
// WLC_IDLE  | waiting for start
// WLC_FETCH | ROM read of filter_count
// WLC_LATCH | ROM data captured into w_data
// WLC_RUN   | weights loaded (strobe on first cycle), fmap pass in progress
// WLC_DONE  | layer complete, filter_finish pulse
module weight_load_ctrl
  import wlc_pkg::*;
#(
  parameter int M        = WLC_M_DEF,
  parameter int N_W      = WLC_N_W_DEF,
  parameter int N_FILTER = WLC_N_FILTER_DEF,
  parameter int ADDR_W   = WLC_ADDR_W_DEF
) (
  input logic                clk,
  input logic                Rst_n,
  weight_load_ctrl_if.master bus
);
  localparam int         W        = M * N_W;
  localparam logic [7:0] LAST_IDX = 8'(N_FILTER - 1);

  wlc_state_e   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   run_cyc_q, run_cyc_d;
  logic [W-1:0] w_data_q, w_data_d;
  logic         is_last;
  logic         pf_issue;
  logic         swap;

  assign is_last = (cnt_q == LAST_IDX);

`ifdef WLC_PREFETCH_EN
  logic         pf_pend_q;
  logic         sh_valid;
  logic [W-1:0] sh_data;

  // prefetch goes out on the second RUN cycle; data lands on mem_dout the cycle after
  assign pf_issue = (state_q == WLC_RUN) && (run_cyc_q == 2'd1) && !is_last;
  assign swap     = (state_q == WLC_RUN) && bus.fmap_finish && sh_valid;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) pf_pend_q <= 1'b0;
    else        pf_pend_q <= pf_issue;
  end

  wlc_shadow_reg #(.W(W)) u_shadow (
    .clk     (clk),
    .Rst_n   (Rst_n),
    .load_i  (pf_pend_q && (state_q == WLC_RUN)),
    .clear_i ((state_q != WLC_RUN) || bus.fmap_finish),
    .d_i     (bus.mem_dout),
    .q_o     (sh_data),
    .valid_o (sh_valid)
  );
`else
  assign pf_issue = 1'b0;
  assign swap     = 1'b0;
`endif

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= WLC_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WLC_IDLE:  if (bus.start) state_d = WLC_FETCH;
      WLC_FETCH: state_d = WLC_LATCH;
      WLC_LATCH: state_d = WLC_RUN;
      WLC_RUN:   if (bus.fmap_finish && !swap) state_d = is_last ? WLC_DONE : WLC_FETCH;
      WLC_DONE:  state_d = WLC_IDLE;
      default:   state_d = WLC_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en        = (state_q == WLC_FETCH) || pf_issue;
    bus.mem_addr      = pf_issue ? ADDR_W'(cnt_q + 8'd1) : ADDR_W'(cnt_q);
    bus.w_valid       = (state_q == WLC_RUN) && (run_cyc_q == 2'd0);
    bus.fmap_start    = (state_q == WLC_RUN) && (run_cyc_q == 2'd0);
    bus.filter_finish = (state_q == WLC_DONE);
    bus.busy          = (state_q != WLC_IDLE);
    bus.filter_count  = cnt_q;
    bus.w_data        = w_data_q;
  end

  // datapath: filter index, weight register and position within the RUN phase
  always_comb begin
    cnt_d    = cnt_q;
    w_data_d = w_data_q;
    if ((state_q == WLC_IDLE && bus.start) || state_q == WLC_DONE) cnt_d = 8'd0;
    if (state_q == WLC_RUN && bus.fmap_finish && !is_last)         cnt_d = cnt_q + 8'd1;
    if (state_q == WLC_LATCH) w_data_d = bus.mem_dout;
`ifdef WLC_PREFETCH_EN
    if (swap) w_data_d = sh_data;
`endif
    run_cyc_d = 2'd0;
    if (state_q == WLC_RUN && state_d == WLC_RUN && !swap)
      run_cyc_d = (run_cyc_q == 2'd2) ? 2'd2 : run_cyc_q + 2'd1;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q     <= 8'd0;
      w_data_q  <= '0;
      run_cyc_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      w_data_q  <= w_data_d;
      run_cyc_q <= run_cyc_d;
    end
  end
endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequencer for the systolic-array weight path. It walks the filter index through N_FILTER filters and fetches each filter's packed weight word from the single-port weight ROM. It presents the weights to the array with a one-cycle load strobe, then starts the feature-map pass. It advances to the next filter on each `fmap_finish` and pulses `filter_finish` after the last filter. It sits between the top-level start logic, the weight ROM, the PE-array weight registers and the fmap buffer.

## Interface
Parameters:
- `M`, 8, weight element width
- `N_W`, 18, weights per filter word (2 PE rows x 9)
- `N_FILTER`, 8, filters per layer
- `ADDR_W`, 8, ROM address width

Ports:
- `clk`  in  1  clock, rising edge
- `Rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a layer
- `fmap_finish`  in  1  one-cycle pulse, fmap pass for current filter done
- `mem_en`  out  1  ROM read enable
- `mem_addr`  out  ADDR_W  ROM address (= filter index)
- `mem_dout`  in  M*N_W  ROM data, valid 1 cycle after `mem_en`
- `w_data`  out  M*N_W  registered weights; element i at [M*(i+1)-1:M*i]
- `w_valid`  out  1  one-cycle load strobe to PE weight registers
- `fmap_start`  out  1  one-cycle pulse, coincident with `w_valid`
- `filter_count`  out  8  current filter index
- `filter_finish`  out  1  one-cycle pulse after last filter
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, LATCH, RUN, DONE.
- IDLE: `start` → FETCH with `filter_count`=0. `fmap_finish` is ignored.
- FETCH: `mem_en`=1, `mem_addr`=`filter_count`. Always → LATCH.
- LATCH: `w_data` <= `mem_dout`. Always → RUN.
- RUN, first cycle: `w_valid`=`fmap_start`=1. The controller then waits for `fmap_finish`.
  - If `fmap_finish` and `filter_count` < N_FILTER-1: `filter_count`++ → FETCH.
  - If `fmap_finish` and `filter_count` = N_FILTER-1: → DONE.
- DONE: `filter_finish`=1 for one cycle, `filter_count` <= 0 → IDLE.
- `start` outside IDLE is ignored. `fmap_finish` outside RUN is ignored.
- `fmap_finish` in the first RUN cycle (same cycle as `w_valid`) is accepted.
- `w_data` holds its value between loads; it changes only in LATCH or on the prefetch swap.
- Reset (any time, including mid-layer): state IDLE. All outputs are 0, `w_data`=0, `filter_count`=0, and the shadow register is invalid. No `filter_finish` is emitted for an aborted layer.

## Timing
- Latency: `start` sampled at edge k → `mem_en` in cycle k+1 → `w_valid`/`fmap_start` in cycle k+3.
- Filter turnaround without prefetch: `fmap_finish` at edge j → `w_valid` in cycle j+3.
- Last filter: `fmap_finish` at edge j → `filter_finish` in cycle j+1 → `busy`=0 in cycle j+2.
- ROM read latency is fixed at 1 cycle. `mem_en` is high for exactly 1 cycle per fetch.

## Configuration
- `WLC_PREFETCH_EN` defined:
  - In the second RUN cycle, if `filter_count` < N_FILTER-1, issue a fetch of `filter_count`+1.
  - Capture the result into a shadow register the following cycle and mark it valid.
  - On `fmap_finish` with shadow valid: `w_data` <= shadow, `filter_count`++, shadow invalidated, stay in RUN. `w_valid`/`fmap_start` fire in cycle j+1.
  - If `fmap_finish` arrives before the shadow is valid, fall back to the FETCH path (j+3).
- Not defined: no shadow register, no RUN-state fetch. Turnaround is always j+3.

## Structure
- Shared package `wlc_pkg`: state enum (`WLC_IDLE`..`WLC_DONE`), weight-element index constants, default N_FILTER.
- No sub-module for the FSM or counter; they stay in this block.
- Natural sub-module: `wlc_shadow_reg` (shadow data register + valid bit), instantiated only under `WLC_PREFETCH_EN`.
- The ROM stays external.

## Test plan
- Reset, then `start` at edge 0: `mem_en`=1 and `mem_addr`=0 in cycle 1; `w_valid`=1 in cycle 3 with `w_data`=ROM[0] (ROM[0][7:0]=1, ROM[0][79:72]=1).
- Full layer, N_FILTER=8, `fmap_finish` 20 cycles after each `w_valid`: 8 `w_valid` pulses at addresses 0..7; exactly one `filter_finish`, one cycle after the 8th `fmap_finish`; `filter_count` returns to 0.
- Spurious inputs: `fmap_finish` in IDLE and `start` in RUN → no state change, no `mem_en`.
- `Rst_n` low during filter 3 RUN → all outputs 0 immediately; a new `start` restarts at address 0.
- `WLC_PREFETCH_EN` defined, `fmap_finish` 10 cycles after `w_valid` → next `w_valid` at j+1 with ROM[n+1]. `fmap_finish` in the first RUN cycle → fallback, `w_valid` at j+3.
